// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder: measures VGA stage lengths, detects stable timing,
// and emits active pixels tagged with x/y coordinates.
// Ports: CLOCK_50/RESET_N clock + async reset; PIX_EN sample strobe;
//   VGA_HS/VS/BLANK_N/R/G/B input stream; pix_valid/x/y/rgb pixel out;
//   h_*_len/v_*_len measured stages; locked; timing_err pulse.
module vga_timing_decoder #(
  parameter int H_W = 11,
  parameter int V_W = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic           CLOCK_50,
  input  logic           RESET_N,
  input  logic           PIX_EN,
  input  logic           VGA_HS,
  input  logic           VGA_VS,
  input  logic           VGA_BLANK_N,
  input  logic [7:0]     VGA_R,
  input  logic [7:0]     VGA_G,
  input  logic [7:0]     VGA_B,
  output logic           pix_valid,
  output logic [H_W-1:0] pix_x,
  output logic [V_W-1:0] pix_y,
  output logic [23:0]    pix_rgb,
  output logic [H_W-1:0] h_sync_len,
  output logic [H_W-1:0] h_bp_len,
  output logic [H_W-1:0] h_act_len,
  output logic [H_W-1:0] h_fp_len,
  output logic [V_W-1:0] v_sync_len,
  output logic [V_W-1:0] v_bp_len,
  output logic [V_W-1:0] v_act_len,
  output logic [V_W-1:0] v_fp_len,
  output logic           locked,
  output logic           timing_err
);

  typedef enum logic [2:0] {
    S_SEARCH, S_SYNC, S_BP, S_ACT, S_FP
  } st_t;

  localparam int HV_W = 4 * H_W;
  localparam int VEC_W = HV_W + 4 * V_W;
  localparam int M_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [H_W-1:0] H_ONE = H_W'(1);
  localparam logic [V_W-1:0] V_ONE = V_W'(1);
  localparam logic [M_W-1:0] LOCK_TH = M_W'(LOCK_FRAMES - 1);

  function automatic logic [H_W-1:0] h_inc(input logic [H_W-1:0] c);
    return (&c) ? c : c + H_ONE;
  endfunction

  function automatic logic [V_W-1:0] v_inc(input logic [V_W-1:0] c);
    return (&c) ? c : c + V_ONE;
  endfunction

  logic           hs_q, vs_q, bl_q;
  st_t            h_st, v_st, h_nx, v_nx;
  logic [H_W-1:0] hc_sync, hc_bp, hc_act, hc_fp;
  logic [H_W-1:0] hs_n, hb_n, ha_n, hf_n;
  logic [V_W-1:0] vc_sync, vc_bp, vc_act, vc_fp;
  logic [V_W-1:0] vs_b, vb_b, va_b, vf_b;
  logic           line_act, h_seen, frame_bad;
  logic [1:0]     phase;
  logic [VEC_W-1:0] vec_q, fvec;
  logic [M_W-1:0] match_cnt, m_inc;
  logic [HV_W-1:0] cur_h, line_vec, nh;
  logic hs_fall, hs_rise, vs_fall, vs_rise, bl_rise, bl_fall;
  logic line_end, line_diff, frame_end, bad_now, pix_hit;

  assign hs_fall = PIX_EN & hs_q & ~VGA_HS;
  assign hs_rise = PIX_EN & ~hs_q & VGA_HS;
  assign vs_fall = PIX_EN & vs_q & ~VGA_VS;
  assign vs_rise = PIX_EN & ~vs_q & VGA_VS;
  assign bl_rise = PIX_EN & ~bl_q & VGA_BLANK_N;
  assign bl_fall = PIX_EN & bl_q & ~VGA_BLANK_N;

  assign cur_h = {h_sync_len, h_bp_len, h_act_len, h_fp_len};
  assign line_vec = {hc_sync, hc_bp, hc_act, hc_fp};

  always_comb begin
    h_nx = h_st;
    hs_n = hc_sync;
    hb_n = hc_bp;
    ha_n = hc_act;
    hf_n = hc_fp;
    line_end = 1'b0;
    if (hs_fall) begin
      line_end = (h_st == S_FP || h_st == S_BP) && line_act;
      h_nx = S_SYNC;
      hs_n = H_ONE;
      hb_n = '0;
      ha_n = '0;
      hf_n = '0;
    end else if (PIX_EN) begin
      unique case (h_st)
        S_SYNC:
          if (hs_rise) begin
            h_nx = S_BP;
            hb_n = H_ONE;
          end else hs_n = h_inc(hc_sync);
        S_BP:
          if (bl_rise) begin
            h_nx = S_ACT;
            ha_n = H_ONE;
          end else hb_n = h_inc(hc_bp);
        S_ACT:
          if (bl_fall) begin
            h_nx = S_FP;
            hf_n = H_ONE;
          end else ha_n = h_inc(hc_act);
        S_FP: hf_n = h_inc(hc_fp);
        default: ;
      endcase
    end
    nh = line_end ? line_vec : cur_h;
    line_diff = line_end && h_seen && (line_vec != cur_h);
  end

  // A line boundary is credited to the stage of the line it closes;
  // the frame end then sees the counts including that boundary.
  always_comb begin
    v_nx = v_st;
    vs_b = vc_sync;
    vb_b = vc_bp;
    va_b = vc_act;
    vf_b = vc_fp;
    if (hs_fall) begin
      unique case (v_st)
        S_SYNC: vs_b = v_inc(vc_sync);
        S_BP:
          if (line_act) begin
            v_nx = S_ACT;
            va_b = V_ONE;
          end else vb_b = v_inc(vc_bp);
        S_ACT:
          if (!line_act) begin
            v_nx = S_FP;
            vf_b = V_ONE;
          end else va_b = v_inc(vc_act);
        S_FP: vf_b = v_inc(vc_fp);
        default: ;
      endcase
    end
    if (vs_rise && v_nx == S_SYNC) v_nx = S_BP;
    frame_end = vs_fall && (v_st != S_SEARCH);
    if (vs_fall) v_nx = S_SYNC;
    fvec = {nh, vs_b, vb_b, va_b, vf_b};
    bad_now = frame_bad | line_diff;
    m_inc = (&match_cnt) ? match_cnt : match_cnt + 1'b1;
    pix_hit = PIX_EN && VGA_BLANK_N && (h_nx == S_ACT)
              && (v_st == S_BP || v_st == S_ACT);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      bl_q <= 1'b0;
      h_st <= S_SEARCH;
      v_st <= S_SEARCH;
      {hc_sync, hc_bp, hc_act, hc_fp} <= '0;
      {vc_sync, vc_bp, vc_act, vc_fp} <= '0;
      {h_sync_len, h_bp_len, h_act_len, h_fp_len} <= '0;
      {v_sync_len, v_bp_len, v_act_len, v_fp_len} <= '0;
      line_act <= 1'b0;
      h_seen <= 1'b0;
      frame_bad <= 1'b0;
      phase <= 2'd0;
      vec_q <= '0;
      match_cnt <= '0;
      locked <= 1'b0;
      timing_err <= 1'b0;
      pix_valid <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      pix_rgb <= '0;
    end else begin
      timing_err <= 1'b0;
      if (PIX_EN) begin
        hs_q <= VGA_HS;
        vs_q <= VGA_VS;
        bl_q <= VGA_BLANK_N;
      end
      if (hs_fall) line_act <= VGA_BLANK_N;
      else if (PIX_EN && VGA_BLANK_N) line_act <= 1'b1;
      h_st <= h_nx;
      v_st <= v_nx;
      {hc_sync, hc_bp, hc_act, hc_fp} <= {hs_n, hb_n, ha_n, hf_n};
      if (vs_fall) {vc_sync, vc_bp, vc_act, vc_fp} <= '0;
      else {vc_sync, vc_bp, vc_act, vc_fp} <= {vs_b, vb_b, va_b, vf_b};
      if (line_end)
        {h_sync_len, h_bp_len, h_act_len, h_fp_len} <= line_vec;
      pix_valid <= pix_hit;
      if (pix_hit) begin
        pix_x <= hc_act;
        pix_y <= vc_act;
        pix_rgb <= {VGA_R, VGA_G, VGA_B};
      end
      if (frame_end) begin
        {v_sync_len, v_bp_len, v_act_len, v_fp_len} <= {vs_b, vb_b, va_b, vf_b};
        frame_bad <= 1'b0;
        h_seen <= 1'b0;
        unique case (phase)
          2'd0: phase <= 2'd1;
          2'd1: begin
            vec_q <= fvec;
            phase <= 2'd2;
          end
          default: begin
            vec_q <= fvec;
            if (fvec == vec_q && !bad_now) begin
              match_cnt <= m_inc;
              locked <= (m_inc >= LOCK_TH);
            end else begin
              match_cnt <= '0;
              locked <= 1'b0;
              timing_err <= 1'b1;
            end
          end
        endcase
      end else begin
        frame_bad <= bad_now;
        h_seen <= h_seen | line_end;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// tb_vga_timing_decoder: directed bench for vga_timing_decoder using a
// reduced mode H 4/3/8/2, V 2/2/5/2 (40 active pixels per frame).
module tb_vga_timing_decoder;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N = 1'b0;
  logic        PIX_EN = 1'b0;
  logic        VGA_HS = 1'b1;
  logic        VGA_VS = 1'b1;
  logic        VGA_BLANK_N = 1'b0;
  logic [7:0]  VGA_R = '0;
  logic [7:0]  VGA_G = '0;
  logic [7:0]  VGA_B = '0;
  logic        pix_valid;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic [23:0] pix_rgb;
  logic [10:0] h_sync_len, h_bp_len, h_act_len, h_fp_len;
  logic [9:0]  v_sync_len, v_bp_len, v_act_len, v_fp_len;
  logic        locked;
  logic        timing_err;

  int checks = 0;
  int errors = 0;
  bit half = 1'b0;

  int pv_total = 0;
  int zero_cnt = 0;
  int consec = 0;
  int err_total = 0;
  logic [23:0] zero_rgb = '0;
  logic [10:0] last_x = '0;
  logic [9:0]  last_y = '0;
  logic        pv_prev = 1'b0;

  vga_timing_decoder dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N(RESET_N),
    .PIX_EN(PIX_EN),
    .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_R(VGA_R),
    .VGA_G(VGA_G),
    .VGA_B(VGA_B),
    .pix_valid(pix_valid),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_rgb(pix_rgb),
    .h_sync_len(h_sync_len),
    .h_bp_len(h_bp_len),
    .h_act_len(h_act_len),
    .h_fp_len(h_fp_len),
    .v_sync_len(v_sync_len),
    .v_bp_len(v_bp_len),
    .v_act_len(v_act_len),
    .v_fp_len(v_fp_len),
    .locked(locked),
    .timing_err(timing_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    pv_prev <= pix_valid;
    if (pix_valid) begin
      pv_total <= pv_total + 1;
      last_x <= pix_x;
      last_y <= pix_y;
      if (pv_prev) consec <= consec + 1;
      if (pix_x == 11'd0 && pix_y == 10'd0) begin
        zero_cnt <= zero_cnt + 1;
        zero_rgb <= pix_rgb;
      end
    end
    if (timing_err) err_total <= err_total + 1;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Off-strobe cycles carry inverted junk that must be ignored.
  task automatic samp(input logic hs, input logic vs, input logic bl,
                      input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b);
    PIX_EN = 1'b1;
    VGA_HS = hs;
    VGA_VS = vs;
    VGA_BLANK_N = bl;
    VGA_R = r;
    VGA_G = g;
    VGA_B = b;
    tick();
    if (half) begin
      PIX_EN = 1'b0;
      VGA_HS = ~hs;
      VGA_VS = ~vs;
      VGA_BLANK_N = ~bl;
      VGA_R = ~r;
      tick();
    end
  endtask

  task automatic line(input int l, input int act_len, input int fp_len);
    logic v;
    logic a;
    v = (l < 2) ? 1'b0 : 1'b1;
    a = (l >= 4 && l < 9);
    for (int i = 0; i < 4; i++) samp(1'b0, v, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) samp(1'b1, v, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < act_len; i++)
      samp(1'b1, v, a, 8'(i), 8'(l - 4), 8'hA5);
    for (int i = 0; i < fp_len; i++) samp(1'b1, v, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic frame(input int odd_ln, input int act_o, input int fp_o);
    for (int l = 0; l < 11; l++) begin
      if (l == odd_ln) line(l, act_o, fp_o);
      else line(l, 8, 2);
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    PIX_EN = 1'b0;
    VGA_HS = 1'b1;
    VGA_VS = 1'b1;
    VGA_BLANK_N = 1'b0;
    repeat (3) tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) samp(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  initial begin
    int pv0;
    int z0;
    int e0;
    int c0;
    tick();
    tick();
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_h_act", 32'(h_act_len), 0);
    chk("rst_v_sync", 32'(v_sync_len), 0);
    chk("rst_err", 32'(timing_err), 0);
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) samp(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);

    frame(-1, 8, 2);
    frame(-1, 8, 2);
    pv0 = pv_total;
    z0 = zero_cnt;
    frame(-1, 8, 2);
    chk("h_sync", 32'(h_sync_len), 4);
    chk("h_bp", 32'(h_bp_len), 3);
    chk("h_act", 32'(h_act_len), 8);
    chk("h_fp", 32'(h_fp_len), 2);
    chk("v_sync", 32'(v_sync_len), 2);
    chk("v_bp", 32'(v_bp_len), 2);
    chk("v_act", 32'(v_act_len), 5);
    chk("v_fp", 32'(v_fp_len), 2);
    chk("locked_before_cmp", 32'(locked), 0);
    chk("pix_per_frame", 32'(pv_total - pv0), 40);
    chk("first_pix_seen", 32'(zero_cnt - z0), 1);
    chk("first_pix_rgb", 32'(zero_rgb), 32'h0000A5);
    chk("last_pix_x", 32'(last_x), 7);
    chk("last_pix_y", 32'(last_y), 4);
    frame(-1, 8, 2);
    chk("locked_after_cmp", 32'(locked), 1);
    chk("no_err_stable", 32'(err_total), 0);

    e0 = err_total;
    frame(6, 7, 2);
    chk("short_line_h_act", 32'(h_act_len), 8);
    chk("locked_pre_short_end", 32'(locked), 1);
    frame(-1, 8, 2);
    chk("short_err_pulse", 32'(err_total - e0), 1);
    chk("short_unlocked", 32'(locked), 0);
    frame(-1, 8, 2);
    chk("short_relocked", 32'(locked), 1);
    chk("short_err_once", 32'(err_total - e0), 1);

    e0 = err_total;
    frame(8, 8, 2100);
    chk("sat_h_fp", 32'(h_fp_len), 2047);
    chk("sat_h_act", 32'(h_act_len), 8);
    frame(-1, 8, 2);
    chk("sat_err", 32'(err_total - e0), 1);
    chk("sat_unlocked", 32'(locked), 0);
    chk("sat_h_fp_back", 32'(h_fp_len), 2);
    frame(-1, 8, 2);
    chk("sat_err_stored", 32'(err_total - e0), 2);
    frame(-1, 8, 2);
    chk("sat_relocked", 32'(locked), 1);

    for (int l = 0; l < 5; l++) line(l, 8, 2);
    for (int i = 0; i < 4; i++) samp(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) samp(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) samp(1'b1, 1'b1, 1'b1, 8'(i), 8'd1, 8'hA5);
    chk("pre_rst_pix", 32'(pix_valid), 1);
    RESET_N = 1'b0;
    #2;
    chk("async_pix_valid", 32'(pix_valid), 0);
    chk("async_pix_x", 32'(pix_x), 0);
    chk("async_locked", 32'(locked), 0);
    chk("async_h_act", 32'(h_act_len), 0);
    chk("async_v_act", 32'(v_act_len), 0);
    pv0 = pv_total;
    PIX_EN = 1'b0;
    repeat (3) tick();
    RESET_N = 1'b1;
    for (int i = 4; i < 8; i++) samp(1'b1, 1'b1, 1'b1, 8'(i), 8'd1, 8'hA5);
    for (int i = 0; i < 2; i++) samp(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int l = 6; l < 11; l++) line(l, 8, 2);
    chk("post_rst_no_pix", 32'(pv_total - pv0), 0);
    chk("post_rst_v_act", 32'(v_act_len), 0);
    pv0 = pv_total;
    frame(-1, 8, 2);
    chk("post_rst_pix", 32'(pv_total - pv0), 40);
    chk("post_rst_unlocked", 32'(locked), 0);

    half = 1'b1;
    do_reset();
    c0 = consec;
    frame(-1, 8, 2);
    frame(-1, 8, 2);
    pv0 = pv_total;
    frame(-1, 8, 2);
    chk("half_h_act", 32'(h_act_len), 8);
    chk("half_h_sync", 32'(h_sync_len), 4);
    chk("half_v_act", 32'(v_act_len), 5);
    chk("half_v_bp", 32'(v_bp_len), 2);
    chk("half_pix", 32'(pv_total - pv0), 40);
    chk("half_locked_pre", 32'(locked), 0);
    frame(-1, 8, 2);
    chk("half_locked", 32'(locked), 1);
    chk("half_no_consec", 32'(consec - c0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_decoder.md
Name: vga_timing_decoder

Overview:
- Receive side of the board's VGA output interface: consumes an HS/VS/BLANK_N/RGB stream with the same 4-stage timing (sync, back porch, display, front porch) the display generator drives.
- Measures every horizontal and vertical stage length and detects stable timing (lock).
- Emits a pixel stream tagged with active-area coordinates, for a frame grabber or loopback checker.
- Runs entirely in the CLOCK_50 domain; a pixel strobe qualifies each sample.

Parameters:
H_W, 11, width of horizontal counters/measurements (pixels)
V_W, 10, width of vertical counters/measurements (lines)
LOCK_FRAMES, 2, consecutive identical full frames required to assert locked (≥2)

Ports:
CLOCK_50  in  1  system clock, all logic rising-edge
RESET_N  in  1  asynchronous active-low reset
PIX_EN  in  1  pixel strobe; inputs sampled only on cycles with PIX_EN=1
VGA_HS  in  1  horizontal sync, active low
VGA_VS  in  1  vertical sync, active low
VGA_BLANK_N  in  1  high in display area
VGA_R / VGA_G / VGA_B  in  8 each  pixel colour
pix_valid  out  1  one-cycle pulse per active pixel
pix_x  out  H_W  active column, 0-based
pix_y  out  V_W  active row, 0-based
pix_rgb  out  24  {R,G,B} of that pixel
h_sync_len, h_bp_len, h_act_len, h_fp_len  out  H_W each  last complete line's stage lengths (pixels)
v_sync_len, v_bp_len, v_act_len, v_fp_len  out  V_W each  last complete frame's stage lengths (lines)
locked  out  1  timing stable
timing_err  out  1  one-cycle pulse on frame mismatch

Behaviour:
- Reset: asynchronous, active-low. All outputs, counters and stored vectors clear to 0; H and V FSMs enter SEARCH; locked=0.
- Edge detection: registered previous HS/VS/BLANK_N, updated only on PIX_EN cycles. Edges exist only on PIX_EN cycles; non-PIX_EN cycles change nothing.
- H FSM (counts PIX_EN samples)
  - SEARCH→SYNC on HS fall.
  - SYNC→BP on HS rise.
  - BP→ACT on BLANK_N rise.
  - ACT→FP on BLANK_N fall.
  - Any state→SYNC on HS fall.
  - Each stage counter counts samples spent in that stage. BP also covers vertical-blank lines (BLANK_N stays low); for those lines, the BP count includes what would otherwise be display+FP.
- Line end: on HS fall from FP or BP, latch h_* from the counters only if the line contained ACT. Blank lines do not update h_*. Then clear the counters.
- Counters saturate at all-ones; a saturated value latches as all-ones.
- V FSM (advances on HS fall = line boundary)
  - SEARCH→SYNC on VS fall.
  - SYNC→BP on VS rise.
  - BP→ACT at the first line boundary ending a line that contained BLANK_N=1.
  - ACT→FP at the first boundary ending a line with no BLANK_N=1.
  - Any state→SYNC on VS fall.
  - Stage counters count line boundaries and saturate.
- Frame end: VS fall with V FSM not in SEARCH.
  - Latch v_*.
  - Form the vector {h_*, v_*}; a line within the frame whose H measurement differs from the previous active line marks the frame bad.
  - First frame end after SEARCH: the partial frame is discarded; nothing is stored.
  - Second frame end: store the vector, no compare.
  - Each later frame end: compare with the stored vector.
    - Match and not bad: match_cnt++ (saturating).
    - Otherwise: match_cnt=0, locked=0, timing_err pulses 1 cycle.
  - Store the new vector in both cases.
  - locked=1 when match_cnt ≥ LOCK_FRAMES−1. Changes take effect the cycle after the VS-fall sample.
- Pixel output: on a PIX_EN cycle with H in ACT, V in BP-transition/ACT and BLANK_N=1, pix_valid=1 one cycle later (latency 1), with pix_x, pix_y and pix_rgb registered.
  - pix_x resets to 0 at the BLANK_N rise and increments per active pixel.
  - pix_y is 0 on the first active line and increments at each boundary in V ACT.
  - pix_valid does not depend on locked.
  - Without PIX_EN there is no pix_valid.
- Simultaneous HS fall and VS fall on one sample: line end is processed first, then frame end; both happen in the same cycle.

Test Plan:
- 640x480 stream, PIX_EN=1 every cycle, H 96/48/640/16, V 2/33/480/10 → after the second full frame, h_*=96/48/640/16 and v_*=2/33/480/10. locked stays 0 until the third frame end (first compare), then 1.
- Same stream → exactly 307200 pix_valid per frame. The first has pix_x=0, pix_y=0 and rgb equal to the driven first pixel; the last has pix_x=639, pix_y=479.
- PIX_EN every other cycle with the same pixel timing → identical measurements and lock. pix_valid pulses never occur on consecutive cycles.
- While locked, one line with 639 active pixels → at that frame end, timing_err pulses once and locked=0. locked returns after LOCK_FRAMES−1 further matching frames.
- HS held high for 3000 samples → the next line end latches h_bp_len or h_fp_len=2047 (saturated). timing_err follows at frame end; no counter wraps.
- RESET_N low mid-display for 3 cycles → all outputs 0 immediately (asynchronous). After release, no pix_valid until the V FSM passes a VS fall and VS rise, then BLANK_N=1.
